// File: rtl/mmio_console_uart.sv
// mmio_console_uart: memory-mapped console / exit responder.
// Console stores queue bytes in a TX FIFO that drains onto an 8N1 UART line.
// The status address reports FIFO state and line activity. A store to the exit
// address latches a sticky exit flag and the first exit code.
module mmio_console_uart #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF0000,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF0004,
  parameter logic [31:0] EXIT_ADDR    = 32'hABCD0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_hit,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        exit_valid,
  output logic [31:0] exit_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            exit_valid_q, exit_valid_d;
  logic [31:0]     exit_code_q, exit_code_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic hit_console, hit_status, hit_exit;
  logic fifo_full, fifo_empty, tx_busy;
  logic push, pop, exit_wr;
  logic [31:0] status_word;

  // Address decode, handshake and load data; a push into a full FIFO stalls.
  always_comb begin
    hit_console = (bus_addr == CONSOLE_ADDR);
    hit_status  = (bus_addr == STATUS_ADDR);
    hit_exit    = (bus_addr == EXIT_ADDR);
    fifo_full   = (count_q == DEPTH_C);
    fifo_empty  = (count_q == '0);
    tx_busy     = (state_q != ST_IDLE);
    bus_hit     = hit_console | hit_status | hit_exit;
    bus_ready   = bus_hit && !(bus_we && hit_console && fifo_full);
    push        = bus_valid && bus_we && hit_console && !fifo_full;
    exit_wr     = bus_valid && bus_we && hit_exit;
    status_word = {16'h0000, 8'(count_q), 5'b00000, tx_busy, fifo_empty, fifo_full};
    bus_rdata   = 32'h0;
    if (bus_valid && !bus_we && bus_ready) begin
      if (hit_status)    bus_rdata = status_word;
      else if (hit_exit) bus_rdata = exit_code_q;
    end
  end

  // UART transmitter: pops a byte on leaving IDLE or at the end of STOP, so
  // back-to-back frames have no idle gap between them.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d   = ST_DATA;
          baud_d    = BAUD_RELOAD;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointers/count and the sticky exit latch.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    exit_valid_d = exit_valid_q;
    exit_code_d  = exit_code_q;
    if (exit_wr && !exit_valid_q) begin
      exit_valid_d = 1'b1;
      exit_code_d  = bus_wdata;
    end
  end

  // Control state with asynchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
    end
  end

  // Datapath storage: FIFO entries and the shift register need no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= bus_wdata[7:0];
  end

  assign uart_tx    = tx_q;
  assign exit_valid = exit_valid_q;
  assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_mmio_console_uart.sv
// Bench for mmio_console_uart: directed bus traffic, a timing-level model of
// the console line and bus responses, and a small UART receiver.
module tb_mmio_console_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_CON  = 32'hFFFF0000;
  localparam logic [31:0] A_STA  = 32'hFFFF0004;
  localparam logic [31:0] A_EXIT = 32'hABCD0000;
  localparam logic [31:0] A_BAD  = 32'hFFFF0008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = 32'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        bus_hit, bus_ready, uart_tx, exit_valid;
  logic [31:0] bus_rdata, exit_code;

  always #5 clk = ~clk;

  mmio_console_uart #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_hit(bus_hit),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .uart_tx(uart_tx),
    .exit_valid(exit_valid), .exit_code(exit_code)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Model: queue of pending bytes plus the start edge of the frame on the line.
  logic [7:0]  m_q[$];
  bit          m_act = 1'b0;
  logic [7:0]  m_cur = 8'h00;
  longint      m_cyc = 0;
  longint      m_s = 0;
  bit          m_ev = 1'b0;
  logic [31:0] m_code = 32'h0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_act  = 1'b0;
        m_ev   = 1'b0;
        m_code = 32'h0;
      end else begin
        bit done, can_push;
        m_cyc++;
        done     = m_act && ((m_cyc - m_s) == longint'(10 * CPB));
        can_push = bus_valid && bus_we && (bus_addr == A_CON) && (m_q.size() < DEPTH);
        if ((!m_act || done) && m_q.size() != 0) begin
          m_cur = m_q.pop_front();
          m_s   = m_cyc;
          m_act = 1'b1;
        end else if (done) begin
          m_act = 1'b0;
        end
        if (can_push) m_q.push_back(bus_wdata[7:0]);
        if (bus_valid && bus_we && bus_addr == A_EXIT && !m_ev) begin
          m_ev   = 1'b1;
          m_code = bus_wdata;
        end
      end
    end
  end

  function automatic logic m_tx();
    longint pos;
    int b;
    if (!m_act) return 1'b1;
    pos = m_cyc - m_s;
    b = int'(pos / CPB);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] st;
    int sz;
    sz = m_q.size();
    st = 32'h0;
    st[0] = (sz == DEPTH);
    st[1] = (sz == 0);
    st[2] = m_act;
    st[15:8] = 8'(sz);
    return st;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      logic exp_hit, exp_rdy;
      logic [31:0] exp_rd;
      @(negedge clk);
      #2;
      exp_hit = (bus_addr == A_CON) || (bus_addr == A_STA) || (bus_addr == A_EXIT);
      exp_rdy = exp_hit && !(bus_we && bus_addr == A_CON && m_q.size() == DEPTH);
      chk("cyc_tx", uart_tx, m_tx());
      chk("cyc_hit", bus_hit, exp_hit);
      chk("cyc_ready", bus_ready, exp_rdy);
      chk("cyc_exit_valid", exit_valid, m_ev);
      chk("cyc_exit_code", exit_code, m_code);
      if (bus_valid && !bus_we && exp_hit) begin
        exp_rd = (bus_addr == A_STA) ? m_status() : (bus_addr == A_EXIT) ? m_code : 32'h0;
        chk("cyc_rdata", bus_rdata, exp_rd);
      end
      if (!exp_hit) chk("cyc_rdata_unmapped", bus_rdata, 32'h0);
    end
  end

  // Line receiver: samples mid-bit, records byte and start time.
  bit          rx_en = 1'b0;
  logic [7:0]  rx_d[$];
  longint      rx_t[$];
  logic [7:0]  rx_b;
  longint      rx_t0;
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && !rst && uart_tx === 1'b0) begin
        rx_t0 = $time;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          rx_b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        if (rx_en && uart_tx === 1'b1) begin
          rx_d.push_back(rx_b);
          rx_t.push_back(rx_t0);
        end
      end
    end
  end

  int stall_cnt = 0;

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus_valid = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (bus_ready) begin
        ok = 1'b1;
        break;
      end
      stall_cnt++;
      @(negedge clk);
    end
    rd = bus_rdata;
    chk("req_accepted", ok, 1'b1);
    @(posedge clk);
    #1;
    bus_valid = 1'b0; bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    req(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    req(1'b0, a, 32'h0, v);
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    st = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      rd(A_STA, st);
      if (st == 32'h2) break;
    end
    chk("drain_idle", st, 32'h2);
  endtask

  logic [9:0]  pat41;
  logic [31:0] v;
  int          lows;

  initial begin
    pat41 = 10'b1010000010;  // index 0 = start bit, LSB-first 0x41, stop bit
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_exit_valid", exit_valid, 1'b0);
    chk("rst_exit_code", exit_code, 32'h0);
    rd(A_STA, v);  chk("rst_status", v, 32'h2);
    rd(A_CON, v);  chk("console_read_zero", v, 32'h0);
    rd(A_EXIT, v); chk("exit_read_zero", v, 32'h0);

    // Single byte 0x41 with exact line timing
    wr(A_CON, 32'h41);
    @(negedge clk); chk("tx_high_push_cycle", uart_tx, 1'b1);
    @(negedge clk); chk("tx_falls_next", uart_tx, 1'b0);
    @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("frame41_bit%0d", b), uart_tx, pat41[b]);
      repeat (4) @(negedge clk);
    end
    rd(A_STA, v); chk("status_after_frame", v, 32'h2);

    // Status mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) wr(A_CON, 32'h60 + i);
    rd(A_STA, v); chk("status_midframe", v, 32'h00000304);
    wait_idle();

    // Back-to-back burst overflowing the FIFO
    rx_d.delete(); rx_t.delete();
    rx_en = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) wr(A_CON, i);
    chk("burst_stalled", (stall_cnt > 0), 1'b1);
    wait_idle();
    rx_en = 1'b0;
    chk("rx_count", rx_d.size(), 20);
    for (int i = 0; i < rx_d.size(); i++) chk($sformatf("rx_byte%0d", i), rx_d[i], i);
    for (int i = 1; i < rx_t.size(); i++)
      chk($sformatf("rx_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'd400);

    // Exit latch
    wr(A_EXIT, 32'h2A);
    chk("exit_valid_set", exit_valid, 1'b1);
    chk("exit_code_42", exit_code, 32'd42);
    wr(A_EXIT, 32'h7);
    chk("exit_code_sticky", exit_code, 32'd42);
    rd(A_EXIT, v); chk("exit_read", v, 32'd42);

    // Unmapped store
    @(negedge clk);
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = A_BAD; bus_wdata = 32'h55;
    #1;
    chk("bad_hit", bus_hit, 1'b0);
    chk("bad_ready", bus_ready, 1'b0);
    chk("bad_rdata", bus_rdata, 32'h0);
    @(posedge clk); #1;
    bus_valid = 1'b0; bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    rd(A_STA, v); chk("bad_no_push", v, 32'h2);
    chk("bad_line_high", uart_tx, 1'b1);

    // Reset during DATA bit 3
    wr(A_CON, 32'h00);
    repeat (19) @(negedge clk);
    chk("tx_low_bit3", uart_tx, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("tx_high_async_rst", uart_tx, 1'b1);
    chk("exit_cleared_rst", exit_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(A_STA, v); chk("status_after_rst", v, 32'h2);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("line_stays_high", lows, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
